vga_render_pipe: RTL and testbench

- Pipelined, frame-synchronous pixel colour generator for the 640x480 game display.
- Consumes pixel coordinates from the VGA timing block and game state from game_logic; drives 12-bit RGB to the VGA output stage.
- Generalises the combinational picture generator:
  - parametrised obstacle count and player geometry;
  - 2-stage registered pipeline with valid alignment;
  - per-frame snapshot of game state, so there is no mid-frame tearing;
  - frame-counted blink effects for pause and game-over.

---
 rtl/vga_render_pkg.sv | 40 ++++
 rtl/vga_render_pipe_if.sv | 33 +++
 rtl/vga_render_pipe_obs_hit_unit.sv | 24 ++
 rtl/vga_render_pipe.sv | 138 +++++++++++++
 tb/tb_vga_render_pipe.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_render_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_render_pkg
// Brief  : Shared mode codes, colours, field widths and pipeline record for
//          the VGA render pipeline.
// Rev    : 1.0  initial release
// ============================================================================
package vga_render_pkg;

  typedef enum logic [1:0] {
    MODE_INIT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_PAUSE = 2'b10,
    MODE_OVER  = 2'b11
  } mode_t;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] ORANGE = 12'hF70;
  localparam logic [11:0] BLUE   = 12'h00F;

  localparam int OBS_X_W = 20;
  localparam int OBS_Y_W = 18;

  // Everything stage 2 needs to pick a colour, captured with the pixel so a
  // snapshot change between stages cannot affect a pixel already in flight.
  typedef struct packed {
    logic  valid;
    logic  top;
    logic  player;
    logic  obs;
    mode_t mode;
    logic  blink;
  } stage1_t;

endpackage
`default_nettype wire

// File: rtl/vga_render_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : vga_render_pipe_if
// Brief  : Pixel/game-state inputs and RGB outputs of the render pipeline.
// Rev    : 1.0  initial release
// ============================================================================
interface vga_render_pipe_if #(
  parameter int N_OBS = 10
);
  logic [9:0]           pix_x;
  logic [8:0]           pix_y;
  logic                 pix_valid;
  logic                 frame_start;
  logic [1:0]           gamemode;
  logic [8:0]           player_y;
  logic [N_OBS*20-1:0]  obstacle_x;
  logic [N_OBS*18-1:0]  obstacle_y;
  logic [11:0]          rgb;
  logic                 rgb_valid;

  modport master (
    output pix_x, pix_y, pix_valid, frame_start, gamemode, player_y,
           obstacle_x, obstacle_y,
    input  rgb, rgb_valid
  );

  modport slave (
    input  pix_x, pix_y, pix_valid, frame_start, gamemode, player_y,
           obstacle_x, obstacle_y,
    output rgb, rgb_valid
  );
endinterface
`default_nettype wire

// File: rtl/vga_render_pipe_obs_hit_unit.sv
`default_nettype none
// ============================================================================
// Module : obs_hit_unit
// Brief  : Combinational hit test of one pixel against one obstacle slot.
// Rev    : 1.0  initial release
// ============================================================================
module obs_hit_unit (
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic [9:0] left,
  input  logic [9:0] right,
  input  logic [8:0] top,
  input  logic [8:0] bottom,
  output logic       hit
);
  logic empty;

  // Degenerate slot marks an unused entry; inverted ranges fail the compare.
  always_comb begin
    empty = (left == right) && (top == bottom);
    hit   = !empty && (x >= left) && (x < right) && (y >= top) && (y < bottom);
  end
endmodule
`default_nettype wire

// File: rtl/vga_render_pipe.sv
`default_nettype none
// ============================================================================
// Module : vga_render_pipe
// Brief  : Two-stage pixel colour generator with per-frame game-state
//          snapshot and frame-counted blink for pause / game-over.
// Rev    : 1.0  initial release
// ============================================================================
module vga_render_pipe
  import vga_render_pkg::*;
#(
  parameter int N_OBS        = 10,
  parameter int PLAYER_X     = 160,
  parameter int PLAYER_SIZE  = 40,
  parameter int UPPER_BOUND  = 40,
  parameter int BLINK_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_render_pipe_if.slave   bus
);
  localparam logic [10:0] PX_LO = 11'(PLAYER_X);
  localparam logic [10:0] PX_HI = 11'(PLAYER_X + PLAYER_SIZE);

  mode_t                sh_mode;
  logic [8:0]           sh_py;
  logic [N_OBS*20-1:0]  sh_ox;
  logic [N_OBS*18-1:0]  sh_oy;
  logic [7:0]           frame_cnt;
  logic                 blink;

  logic [N_OBS-1:0]     obs_hits;
  logic                 player_hit;
  logic                 top_band;
  logic [9:0]           py_end;
  stage1_t              s1;
  logic [11:0]          colour;
  logic [11:0]          bg;

  // Snapshot game state and advance the blink counter once per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_mode   <= MODE_INIT;
      sh_py     <= '0;
      sh_ox     <= '0;
      sh_oy     <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (bus.frame_start) begin
      sh_mode <= mode_t'(bus.gamemode);
      sh_py   <= bus.player_y;
      sh_ox   <= bus.obstacle_x;
      sh_oy   <= bus.obstacle_y;
      if (bus.gamemode != sh_mode) begin
        frame_cnt <= '0;
        blink     <= 1'b0;
      end else if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  generate
    for (genvar i = 0; i < N_OBS; i++) begin : g_obs
      obs_hit_unit u_hit (
        .x      (bus.pix_x),
        .y      (bus.pix_y),
        .left   (sh_ox[i*OBS_X_W +: 10]),
        .right  (sh_ox[i*OBS_X_W + 10 +: 10]),
        .top    (sh_oy[i*OBS_Y_W +: 9]),
        .bottom (sh_oy[i*OBS_Y_W + 9 +: 9]),
        .hit    (obs_hits[i])
      );
    end
  endgenerate

  // Player square and top-band tests; py end is 10 bits so it never wraps.
  always_comb begin
    py_end     = {1'b0, sh_py} + 10'(PLAYER_SIZE);
    player_hit = ({1'b0, bus.pix_x} >= PX_LO) && ({1'b0, bus.pix_x} < PX_HI) &&
                 (bus.pix_y >= sh_py) && ({1'b0, bus.pix_y} < py_end);
    top_band   = ({1'b0, bus.pix_y} <= 10'(UPPER_BOUND));
  end

  // Stage 1: register hit results together with the frame's mode and blink.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '{valid: 1'b0, top: 1'b0, player: 1'b0, obs: 1'b0,
              mode: MODE_INIT, blink: 1'b0};
    end else begin
      s1.valid  <= bus.pix_valid;
      s1.top    <= top_band;
      s1.player <= player_hit;
      s1.obs    <= |obs_hits;
      s1.mode   <= sh_mode;
      s1.blink  <= blink;
    end
  end

  // Colour priority: invalid/top band black, init green, player, obstacle, bg.
  always_comb begin
    case (s1.mode)
      MODE_RUN:   bg = WHITE;
      MODE_PAUSE: bg = YELLOW;
      MODE_OVER:  bg = RED;
      default:    bg = GREEN;
    endcase
    colour = bg;
    if (!s1.valid || s1.top) begin
      colour = BLACK;
    end else if (s1.mode == MODE_INIT) begin
      colour = GREEN;
    end else if (s1.player) begin
      case (s1.mode)
        MODE_PAUSE: colour = s1.blink ? bg : BLUE;
        MODE_OVER:  colour = s1.blink ? WHITE : BLUE;
        default:    colour = BLUE;
      endcase
    end else if (s1.obs) begin
      colour = ORANGE;
    end
  end

  // Stage 2: register the final colour and its valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rgb       <= BLACK;
      bus.rgb_valid <= 1'b0;
    end else begin
      bus.rgb       <= colour;
      bus.rgb_valid <= s1.valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_render_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_render_pipe
// Brief  : Self-checking bench: directed scenarios plus random pixels and
//          frames compared against a behavioural colour model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_render_pipe;
  localparam int N_OBS = 10;
  localparam int PX    = 160;
  localparam int PS    = 40;
  localparam int UB    = 40;
  localparam int BF    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_render_pipe_if #(.N_OBS(N_OBS)) bus ();

  vga_render_pipe #(
    .N_OBS(N_OBS), .PLAYER_X(PX), .PLAYER_SIZE(PS),
    .UPPER_BOUND(UB), .BLINK_FRAMES(BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model of the latched game state; blink derives from frames spent in mode.
  int m_mode, m_py, m_frames;
  logic [N_OBS*20-1:0] m_ox;
  logic [N_OBS*18-1:0] m_oy;
  logic [12:0] expq[$];
  logic [11:0] seen_rgb;
  logic        seen_valid;

  task automatic check_val(input string tag, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_colour(input int x, input int y, input bit v);
    int blink, l, r, t, b;
    logic [11:0] bg;
    bit ph, oh;
    blink = (m_frames / BF) % 2;
    if (!v || y <= UB) return 12'h000;
    if (m_mode == 0) return 12'h0F0;
    bg = (m_mode == 1) ? 12'hFFF : (m_mode == 2) ? 12'hFF0 : 12'hF00;
    ph = (x >= PX) && (x < PX + PS) && (y >= m_py) && (y < m_py + PS);
    oh = 0;
    for (int i = 0; i < N_OBS; i++) begin
      l = int'(m_ox[i*20 +: 10]);
      r = int'(m_ox[i*20+10 +: 10]);
      t = int'(m_oy[i*18 +: 9]);
      b = int'(m_oy[i*18+9 +: 9]);
      if (!(l == r && t == b) && x >= l && x < r && y >= t && y < b) oh = 1;
    end
    if (ph) begin
      if (m_mode == 1) return 12'h00F;
      if (m_mode == 2) return blink ? bg : 12'h00F;
      return blink ? 12'hFFF : 12'h00F;
    end
    if (oh) return 12'hF70;
    return bg;
  endfunction

  // One cycle: check the pixel driven two cycles ago, then drive the next.
  task automatic step(input int x, input int y, input bit v, input bit fs, input bit rst);
    logic [12:0] e;
    int nm;
    @(negedge clk);
    seen_rgb   = bus.rgb;
    seen_valid = bus.rgb_valid;
    if (expq.size() == 2) begin
      e = expq.pop_front();
      check_val("rgb", seen_rgb, e[11:0]);
      check_val("rgb_valid", {11'b0, seen_valid}, {11'b0, e[12]});
    end
    bus.pix_x       = 10'(x);
    bus.pix_y       = 9'(y);
    bus.pix_valid   = v;
    bus.frame_start = fs;
    rst_n           = !rst;
    if (rst) begin
      foreach (expq[i]) expq[i] = '0;
      expq.push_back('0);
      m_mode = 0; m_py = 0; m_frames = 0; m_ox = '0; m_oy = '0;
    end else begin
      expq.push_back({v, ref_colour(x, y, v)});
      if (fs) begin
        nm = int'(bus.gamemode);
        if (nm != m_mode) m_frames = 0;
        else m_frames++;
        m_mode = nm;
        m_py   = int'(bus.player_y);
        m_ox   = bus.obstacle_x;
        m_oy   = bus.obstacle_y;
      end
    end
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic [11:0] want);
    step(x, y, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_val(tag, seen_rgb, want);
  endtask

  task automatic frame();
    step(0, 0, 0, 1, 0);
  endtask

  task automatic set_slot(input int i, input int l, input int r, input int t, input int b);
    bus.obstacle_x[i*20 +: 10]   = 10'(l);
    bus.obstacle_x[i*20+10 +: 10] = 10'(r);
    bus.obstacle_y[i*18 +: 9]    = 9'(t);
    bus.obstacle_y[i*18+9 +: 9]  = 9'(b);
  endtask

  initial begin
    int l, t;
    bus.pix_x = '0; bus.pix_y = '0; bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
    bus.gamemode = 2'b00; bus.player_y = '0; bus.obstacle_x = '0; bus.obstacle_y = '0;
    m_mode = 0; m_py = 0; m_frames = 0; m_ox = '0; m_oy = '0;

    repeat (3) step(0, 0, 0, 0, 1);

    // Reset state renders green; top band black.
    step(100, 200, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_val("tp1_green", seen_rgb, 12'h0F0);
    check_val("tp1_valid", {11'b0, seen_valid}, 12'h001);
    probe("tp1_top", 100, 30, 12'h000);

    // Run mode snapshot.
    bus.gamemode = 2'b01; bus.player_y = 9'd200;
    set_slot(0, 300, 340, 100, 150);
    frame();
    probe("tp2_player", 170, 210, 12'h00F);
    probe("tp2_obs", 310, 120, 12'hF70);
    probe("tp2_bg", 500, 300, 12'hFFF);
    probe("tp2_pl_edge_in", 199, 239, 12'h00F);
    probe("tp2_pl_edge_out", 200, 240, 12'hFFF);

    // No tearing until the next frame_start.
    bus.player_y = 9'd300;
    probe("tp3_old", 170, 210, 12'h00F);
    frame();
    probe("tp3_new_old_pos", 170, 210, 12'hFFF);
    probe("tp3_new_pos", 170, 310, 12'h00F);

    // Pause blink.
    bus.gamemode = 2'b10;
    frame();
    probe("tp4_f0", 170, 310, 12'h00F);
    frame();
    probe("tp4_f1", 170, 310, 12'h00F);
    frame();
    probe("tp4_f2", 170, 310, 12'hFF0);
    frame();
    frame();
    probe("tp4_f4", 170, 310, 12'h00F);

    // Game over: player over obstacle, red background, blink to white.
    bus.gamemode = 2'b11;
    set_slot(1, 150, 250, 290, 360);
    frame();
    probe("tp5_player", 170, 310, 12'h00F);
    probe("tp5_bg", 400, 400, 12'hF00);
    probe("tp5_obs", 220, 320, 12'hF70);
    frame();
    frame();
    probe("tp5_blink", 170, 310, 12'hFFF);

    // Overlapping slots, empty slot, invalid pixel.
    bus.gamemode = 2'b01; bus.obstacle_x = '0; bus.obstacle_y = '0;
    set_slot(3, 400, 450, 100, 150);
    set_slot(9, 430, 500, 120, 200);
    set_slot(5, 50, 50, 60, 60);
    frame();
    probe("tp6_both", 440, 130, 12'hF70);
    probe("tp6_s9", 480, 180, 12'hF70);
    probe("tp6_s3", 410, 110, 12'hF70);
    probe("tp6_empty", 50, 60, 12'hFFF);
    step(440, 130, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_val("tp6_inv_rgb", seen_rgb, 12'h000);
    check_val("tp6_inv_valid", {11'b0, seen_valid}, 12'h000);

    // Mid-frame reset returns to green.
    step(440, 130, 1, 0, 1);
    probe("rst_green", 440, 130, 12'h0F0);

    // Random pixels, frames and occasional resets against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        bus.gamemode = 2'($urandom_range(0, 3));
        bus.player_y = 9'($urandom_range(0, 479));
        for (int i = 0; i < N_OBS; i++) begin
          if ($urandom_range(0, 1) == 0) set_slot(i, 0, 0, 0, 0);
          else begin
            l = int'($urandom_range(0, 600));
            t = int'($urandom_range(0, 440));
            set_slot(i, l, l + int'($urandom_range(0, 100)), t, t + int'($urandom_range(0, 60)));
          end
        end
        frame();
      end else if (r == 3) begin
        step(0, 0, 0, 0, 1);
      end else if (r < 50) begin
        step(int'($urandom_range(120, 260)), int'($urandom_range(0, 479)),
             bit'($urandom_range(0, 1)), 0, 0);
      end else begin
        step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
             bit'($urandom_range(0, 1)), 0, 0);
      end
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
